// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC selection (seq / PC-relative / BR / RET),
// stall, and a circular return-address stack fed by BL and drained by RET.
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_BYTES = 4,
  parameter int unsigned           IMM_SHIFT   = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           RAS_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  input  logic                  Stall,
  input  logic                  Branch,
  input  logic                  BranchInvert,
  input  logic                  ALUZero,
  input  logic                  Uncondbranch,
  input  logic                  RegBranch,
  input  logic                  Link,
  input  logic                  Ret,
  input  logic [ADDR_WIDTH-1:0] SignExtImm,
  input  logic [ADDR_WIDTH-1:0] RegTarget,
  output logic [ADDR_WIDTH-1:0] CurrentPC,
  output logic [ADDR_WIDTH-1:0] NextPC,
  output logic [ADDR_WIDTH-1:0] LinkAddr,
  output logic                  Taken,
  output logic                  RASEmpty,
  output logic                  RASFull,
  output logic                  RASMiss
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]         top, top_inc, top_dec, top_nxt, wr_ptr;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  wr_en, cond_taken;
  logic [ADDR_WIDTH-1:0] rel_tgt, ras_top;

  assign LinkAddr   = CurrentPC + ADDR_WIDTH'(INSTR_BYTES);
  assign rel_tgt    = CurrentPC + (SignExtImm << IMM_SHIFT);
  assign ras_top    = ras[top];
  assign RASEmpty   = (cnt == '0);
  assign RASFull    = (cnt == CW'(RAS_DEPTH));
  assign RASMiss    = Ret && RASEmpty;
  assign cond_taken = Branch && (ALUZero ^ BranchInvert);

  // Pointer arithmetic is modulo RAS_DEPTH, which need not be a power of two.
  assign top_inc = (top == LAST) ? '0 : top + PW'(1);
  assign top_dec = (top == '0) ? LAST : top - PW'(1);

  always_comb begin
    NextPC = LinkAddr;
    Taken  = 1'b1;
    if (Ret)                             NextPC = RASEmpty ? RegTarget : ras_top;
    else if (RegBranch)                  NextPC = RegTarget;
    else if (Uncondbranch || cond_taken) NextPC = rel_tgt;
    else                                 Taken  = 1'b0;
  end

  // Push onto a full stack lands on top_inc, which is the oldest entry.
  always_comb begin
    wr_en   = 1'b0;
    wr_ptr  = top;
    top_nxt = top;
    cnt_nxt = cnt;
    if (!Stall) begin
      if (Link && Ret && !RASEmpty) begin
        wr_en = 1'b1;
      end else if (Link) begin
        wr_en   = 1'b1;
        wr_ptr  = top_inc;
        top_nxt = top_inc;
        if (!RASFull) cnt_nxt = cnt + CW'(1);
      end else if (Ret && !RASEmpty) begin
        top_nxt = top_dec;
        cnt_nxt = cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      CurrentPC <= RESET_PC;
      top       <= '0;
      cnt       <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras[i] <= '0;
    end else begin
      if (!Stall) CurrentPC <= NextPC;
      top <= top_nxt;
      cnt <= cnt_nxt;
      for (int i = 0; i < int'(RAS_DEPTH); i++)
        if (wr_en && wr_ptr == PW'(i)) ras[i] <= LinkAddr;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: constant vector table, directed
// multi-cycle sequences, and random stimulus against a queue-based model.
module tb_pc_sequencer;
  localparam int AW = 64;
  localparam int D  = 4;

  logic          CLK = 1'b0;
  logic          Reset_L, Stall, Branch, BranchInvert, ALUZero;
  logic          Uncondbranch, RegBranch, Link, Ret;
  logic [AW-1:0] SignExtImm, RegTarget;
  logic [AW-1:0] CurrentPC, NextPC, LinkAddr;
  logic          Taken, RASEmpty, RASFull, RASMiss;

  pc_sequencer #(.ADDR_WIDTH(AW), .INSTR_BYTES(4), .IMM_SHIFT(2),
                 .RESET_PC('0), .RAS_DEPTH(D)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall), .Branch(Branch),
    .BranchInvert(BranchInvert), .ALUZero(ALUZero), .Uncondbranch(Uncondbranch),
    .RegBranch(RegBranch), .Link(Link), .Ret(Ret), .SignExtImm(SignExtImm),
    .RegTarget(RegTarget), .CurrentPC(CurrentPC), .NextPC(NextPC),
    .LinkAddr(LinkAddr), .Taken(Taken), .RASEmpty(RASEmpty), .RASFull(RASFull),
    .RASMiss(RASMiss));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  // Reference model: PC value plus a queue of return addresses, newest at the back.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q [$];

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    Stall = 0; Branch = 0; BranchInvert = 0; ALUZero = 0; Uncondbranch = 0;
    RegBranch = 0; Link = 0; Ret = 0; SignExtImm = '0; RegTarget = '0;
  endtask

  function automatic void model_next(output logic [AW-1:0] nxt, output logic tk,
                                     output logic miss);
    miss = 1'b0;
    tk   = 1'b1;
    if (Ret) begin
      miss = (m_q.size() == 0);
      nxt  = miss ? RegTarget : m_q[m_q.size()-1];
    end else if (RegBranch) begin
      nxt = RegTarget;
    end else if (Uncondbranch || (Branch && (ALUZero != BranchInvert))) begin
      nxt = m_pc + SignExtImm * 4;
    end else begin
      nxt = m_pc + 4;
      tk  = 1'b0;
    end
  endfunction

  // One clock with current inputs: check combinational outputs, then state after the edge.
  task automatic cyc();
    logic [AW-1:0] nxt, la;
    logic tk, miss;
    @(negedge CLK);
    model_next(nxt, tk, miss);
    la = m_pc + 4;
    chk("NextPC", NextPC, nxt);
    chk("Taken", AW'(Taken), AW'(tk));
    chk("LinkAddr", LinkAddr, la);
    chk("RASMiss", AW'(RASMiss), AW'(miss));
    @(posedge CLK);
    if (!Stall) begin
      if (Link && Ret && m_q.size() > 0) m_q[m_q.size()-1] = la;
      else if (Link) begin
        m_q.push_back(la);
        if (m_q.size() > D) void'(m_q.pop_front());
      end else if (Ret && m_q.size() > 0) void'(m_q.pop_back());
      m_pc = nxt;
    end
    #1;
    chk("CurrentPC", CurrentPC, m_pc);
    chk("RASEmpty", AW'(RASEmpty), AW'(m_q.size() == 0));
    chk("RASFull", AW'(RASFull), AW'(m_q.size() == D));
  endtask

  // Reset pulsed between edges; effect must be visible before the next edge.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    idle();
    Reset_L = 0;
    #2;
    m_pc = '0;
    m_q.delete();
    chk("rst_CurrentPC", CurrentPC, '0);
    chk("rst_RASEmpty", AW'(RASEmpty), AW'(1));
    chk("rst_RASFull", AW'(RASFull), AW'(0));
    chk("rst_NextPC", NextPC, 64'h4);
    Reset_L = 1;
  endtask

  typedef struct {
    string         nm;
    bit            br, inv, z, unc, rb, rt;
    logic [AW-1:0] start, imm, regt, exp_next;
    bit            exp_tk;
  } vec_t;

  vec_t vt [10];
  logic [AW-1:0] ret_exp [4];

  initial begin
    idle();
    Reset_L = 0;
    m_pc = '0;
    #12;
    Reset_L = 1;

    vt[0] = '{"cbz_taken",   1,0,1,0,0,0, 64'h100, -64'sd2, 64'h0, 64'hF8, 1};
    vt[1] = '{"cbnz_nt",     1,1,1,0,0,0, 64'h100, -64'sd2, 64'h0, 64'h104, 0};
    vt[2] = '{"cbnz_taken",  1,1,0,0,0,0, 64'h100, 64'h8, 64'h0, 64'h120, 1};
    vt[3] = '{"cbz_nt",      1,0,0,0,0,0, 64'h100, 64'h8, 64'h0, 64'h104, 0};
    vt[4] = '{"wrap_seq",    0,0,0,0,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0, 0};
    vt[5] = '{"wrap_rel",    0,0,0,1,0,0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8, 64'h0, 64'h10, 1};
    vt[6] = '{"br",          0,0,0,0,1,0, 64'h100, 64'h0, 64'hDEAD0, 64'hDEAD0, 1};
    vt[7] = '{"prio_rb_unc", 0,0,0,1,1,0, 64'h100, 64'h4, 64'h500, 64'h500, 1};
    vt[8] = '{"prio_ret_rb", 0,0,0,0,1,1, 64'h100, 64'h4, 64'h700, 64'h700, 1};
    vt[9] = '{"shift_drop",  0,0,0,1,0,0, 64'h0, 64'h4000_0000_0000_0001, 64'h0, 64'h4, 1};

    // Sequential fetch from reset
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("seq_pc", CurrentPC, AW'(4 * i));
    end

    // Vector table: steer PC with BR, then apply controls and check
    for (int i = 0; i < 10; i++) begin
      idle();
      RegBranch = 1; RegTarget = vt[i].start;
      cyc();
      idle();
      Branch = vt[i].br; BranchInvert = vt[i].inv; ALUZero = vt[i].z;
      Uncondbranch = vt[i].unc; RegBranch = vt[i].rb; Ret = vt[i].rt;
      SignExtImm = vt[i].imm; RegTarget = vt[i].regt;
      #2;
      chk({vt[i].nm, "_next"}, NextPC, vt[i].exp_next);
      chk({vt[i].nm, "_taken"}, AW'(Taken), AW'(vt[i].exp_tk));
      cyc();
    end

    // BL then RET
    do_reset();
    RegBranch = 1; RegTarget = 64'h200;
    cyc();
    idle(); Uncondbranch = 1; Link = 1; SignExtImm = 64'h40;
    cyc();
    chk("bl_pc", CurrentPC, 64'h300);
    idle(); Ret = 1;
    #2;
    chk("ret_next", NextPC, 64'h204);
    cyc();
    chk("ret_empty", AW'(RASEmpty), AW'(1));

    // Overflow: five BLs into a depth-4 stack, then drain and miss
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); Uncondbranch = 1; Link = 1; SignExtImm = 64'h4;
      cyc();
    end
    chk("ovf_full", AW'(RASFull), AW'(1));
    chk("ovf_pc", CurrentPC, 64'h50);
    ret_exp[0] = 64'h44; ret_exp[1] = 64'h34; ret_exp[2] = 64'h24; ret_exp[3] = 64'h14;
    for (int i = 0; i < 4; i++) begin
      idle(); Ret = 1;
      #2;
      chk("ovf_ret", NextPC, ret_exp[i]);
      cyc();
    end
    idle(); Ret = 1; RegTarget = 64'hABC;
    #2;
    chk("miss_next", NextPC, 64'hABC);
    chk("miss_flag", AW'(RASMiss), AW'(1));
    cyc();

    // Stall holds PC and stack; release produces one push
    do_reset();
    Stall = 1; Uncondbranch = 1; Link = 1; SignExtImm = 64'h10;
    #2;
    chk("stall_next", NextPC, 64'h40);
    repeat (3) cyc();
    chk("stall_pc", CurrentPC, 64'h0);
    chk("stall_empty", AW'(RASEmpty), AW'(1));
    Stall = 0;
    cyc();
    chk("unstall_pc", CurrentPC, 64'h40);
    idle(); Ret = 1;
    #2;
    chk("unstall_ret", NextPC, 64'h4);
    cyc();
    chk("single_push", AW'(RASEmpty), AW'(1));

    // Random stimulus against the model, with a mid-run reset
    do_reset();
    for (int n = 0; n < 500; n++) begin
      int r;
      if (n == 250) do_reset();
      r = $urandom_range(0, 63) - 32;
      Stall        = ($urandom_range(0, 5) == 0);
      Branch       = ($urandom_range(0, 3) == 0);
      BranchInvert = $urandom_range(0, 1);
      ALUZero      = $urandom_range(0, 1);
      Uncondbranch = ($urandom_range(0, 4) == 0);
      RegBranch    = ($urandom_range(0, 7) == 0);
      Link         = ($urandom_range(0, 2) == 0);
      Ret          = ($urandom_range(0, 2) == 0);
      SignExtImm   = {{32{r[31]}}, r};
      RegTarget    = {$urandom, $urandom} & ~64'h3;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
